// File: rtl/delta_writer.sv
// Rebuilds absolute samples from a signed difference stream and writes them to consecutive
// addresses. Define DELTA_WRITER_SAT_EN to clamp on overflow instead of wrapping.
module delta_writer #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] seed,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   len,
  input  logic [DATA_W-1:0] diff_in,
  input  logic              diff_valid,
  output logic              diff_ready,
  output logic              wen,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic              ovf
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  localparam logic [ADDR_W:0]   CountOne = 1;
  localparam logic [ADDR_W-1:0] PtrOne   = 1;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] acc_q, wdata_q, sum_raw, sum;
  logic [ADDR_W:0]   count_q;
  logic [ADDR_W-1:0] ptr_q, waddr_q;
  logic              wen_q, done_q, ovf_q;
  logic              accept, ovf_beat, last_beat;

  assign diff_ready = (state_q == StRun);
  assign accept     = diff_valid && diff_ready;
  assign last_beat  = (count_q == CountOne);
  assign sum_raw    = acc_q + diff_in;
  // Signed overflow: operands agree in sign, result does not.
  assign ovf_beat   = (acc_q[DATA_W-1] == diff_in[DATA_W-1]) &&
                      (sum_raw[DATA_W-1] != acc_q[DATA_W-1]);

`ifdef DELTA_WRITER_SAT_EN
  always_comb begin
    sum = sum_raw;
    if (ovf_beat) begin
      sum = acc_q[DATA_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    end
  end
`else
  assign sum = sum_raw;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start && (len != '0)) state_d = StRun;
      StRun:   if (accept && last_beat) state_d = StDrain;
      StDrain: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      acc_q   <= '0;
      count_q <= '0;
      ptr_q   <= '0;
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wen_q   <= 1'b0;
      done_q  <= 1'b0;
      if ((state_q == StIdle) && start) begin
        acc_q   <= seed;
        ptr_q   <= base_addr;
        count_q <= len;
        ovf_q   <= 1'b0;
        done_q  <= (len == '0);
      end
      if (accept) begin
        acc_q   <= sum;
        count_q <= count_q - CountOne;
        wen_q   <= 1'b1;
        waddr_q <= ptr_q;
        wdata_q <= sum;
        ptr_q   <= ptr_q + PtrOne;
        if (ovf_beat) ovf_q <= 1'b1;
        // Done lands together with the final write, i.e. in the DRAIN cycle.
        if (last_beat) done_q <= 1'b1;
      end
    end
  end

  assign wen   = wen_q;
  assign waddr = waddr_q;
  assign wdata = wdata_q;
  assign done  = done_q;
  assign ovf   = ovf_q;
  assign busy  = (state_q == StRun) || (state_q == StDrain);

endmodule

// File: tb/tb_delta_writer.sv
// Scoreboard bench for delta_writer: directed transfers push hand-computed writes; a negedge
// monitor pops and compares every write / done event.
module tb_delta_writer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] seed = '0;
  logic [3:0] base_addr = '0;
  logic [4:0] len = '0;
  logic [7:0] diff_in = '0;
  logic       diff_valid = 1'b0;
  logic       diff_ready, wen, busy, done, ovf;
  logic [3:0] waddr;
  logic [7:0] wdata;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       wen;
    logic [3:0] addr;
    logic [7:0] data;
    logic       ovf;
    logic       done;
  } exp_t;

  exp_t exp_q[$];

  delta_writer #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .seed       (seed),
    .base_addr  (base_addr),
    .len        (len),
    .diff_in    (diff_in),
    .diff_valid (diff_valid),
    .diff_ready (diff_ready),
    .wen        (wen),
    .waddr      (waddr),
    .wdata      (wdata),
    .busy       (busy),
    .done       (done),
    .ovf        (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic w, input logic [3:0] a, input logic [7:0] d,
                      input logic o, input logic dn);
    exp_t e;
    e.wen = w; e.addr = a; e.data = d; e.ovf = o; e.done = dn;
    exp_q.push_back(e);
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst_n && (wen || done)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", {wen, done}, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("wen", int'(wen), int'(e.wen));
        check("done", int'(done), int'(e.done));
        check("ovf", int'(ovf), int'(e.ovf));
        if (e.wen) begin
          check("waddr", int'(waddr), int'(e.addr));
          check("wdata", int'(wdata), int'(e.data));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_xfer(input logic [7:0] s, input logic [3:0] b, input logic [4:0] l);
    start = 1'b1; seed = s; base_addr = b; len = l;
    tick();
    start = 1'b0;
  endtask

  task automatic beat(input logic [7:0] d);
    diff_valid = 1'b1; diff_in = d;
    tick();
    diff_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wen"}, int'(wen), 0);
    check({tag, "_waddr"}, int'(waddr), 0);
    check({tag, "_wdata"}, int'(wdata), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_ovf"}, int'(ovf), 0);
    check({tag, "_ready"}, int'(diff_ready), 0);
  endtask

  initial begin
    #1;
    check_all_zero("reset");
    #20;
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Basic run.
    push(1, 4'd2, 8'h15, 0, 0);
    push(1, 4'd3, 8'h13, 0, 0);
    push(1, 4'd4, 8'h13, 0, 1);
    start_xfer(8'h10, 4'd2, 5'd3);
    check("run_busy", int'(busy), 1);
    check("run_ready", int'(diff_ready), 1);
    diff_valid = 1'b1;
    diff_in = 8'h05; tick();
    diff_in = 8'hFE; tick();
    diff_in = 8'h00; tick();
    diff_valid = 1'b0;
    check("drain_ready", int'(diff_ready), 0);
    check("drain_busy", int'(busy), 1);
    idle(3);
    check("idle_busy", int'(busy), 0);

    // Positive overflow.
`ifdef DELTA_WRITER_SAT_EN
    push(1, 4'd0, 8'h7F, 1, 1);
`else
    push(1, 4'd0, 8'h80, 1, 1);
`endif
    start_xfer(8'h7F, 4'd0, 5'd1);
    beat(8'h01);
    idle(3);

    // Negative overflow.
`ifdef DELTA_WRITER_SAT_EN
    push(1, 4'd0, 8'h80, 1, 1);
`else
    push(1, 4'd0, 8'h7F, 1, 1);
`endif
    start_xfer(8'h80, 4'd0, 5'd1);
    beat(8'hFF);
    idle(3);
    check("ovf_sticky_idle", int'(ovf), 1);

    // Len=0: Done one cycle after Start, no write, Ovf cleared.
    push(0, 4'd0, 8'h00, 0, 1);
    start_xfer(8'h33, 4'd9, 5'd0);
    check("len0_busy", int'(busy), 0);
    idle(3);

    // Gapped valid with address wrap.
    push(1, 4'd14, 8'h01, 0, 0);
    push(1, 4'd15, 8'h03, 0, 0);
    push(1, 4'd0, 8'h06, 0, 0);
    push(1, 4'd1, 8'h0A, 0, 1);
    start_xfer(8'h00, 4'd14, 5'd4);
    beat(8'h01); tick();
    beat(8'h02); tick();
    beat(8'h03); tick();
    beat(8'h04);
    idle(3);

    // Start while busy must be ignored.
    push(1, 4'd5, 8'h21, 0, 0);
    push(1, 4'd6, 8'h23, 0, 0);
    push(1, 4'd7, 8'h26, 0, 1);
    start_xfer(8'h20, 4'd5, 5'd3);
    beat(8'h01);
    start = 1'b1; seed = 8'h70; base_addr = 4'd0; len = 5'd2;
    beat(8'h02);
    start = 1'b0;
    beat(8'h03);
    idle(3);

    // DiffValid while idle is not accepted.
    diff_valid = 1'b1; diff_in = 8'h11;
    idle(3);
    check("idle_ready", int'(diff_ready), 0);
    diff_valid = 1'b0;

    // Reset mid-run: second beat's pending write is dropped.
`ifdef DELTA_WRITER_SAT_EN
    push(1, 4'd0, 8'h7F, 1, 0);
`else
    push(1, 4'd0, 8'h80, 1, 0);
`endif
    start_xfer(8'h7F, 4'd0, 5'd5);
    beat(8'h01);
    beat(8'h01);
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    idle(2);
    check("midrst_wen_hold", int'(wen), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    push(1, 4'd3, 8'h42, 0, 1);
    start_xfer(8'h40, 4'd3, 5'd1);
    check("post_rst_ovf", int'(ovf), 0);
    beat(8'h02);
    idle(4);

    check("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/delta_writer.md
Name: delta_writer

Overview:
- Inverse of the difference path: takes a stream of signed 8-bit differences (DOut2 - DOut1 form) and rebuilds absolute samples as Acc[n] = Acc[n-1] + Diff[n].
- Writes each rebuilt sample into the destination memory at consecutive addresses.
- Sits between the difference source and the destination RAM write port in the memory-to-memory transfer datapath.

Parameters:
- DATA_W, 8, sample/difference width (two's complement)
- ADDR_W, 4, destination address width; max transfer 2^ADDR_W words

Ports:
- Clk  input  1  system clock, rising edge
- Rst_n  input  1  asynchronous active-low reset
- Start  input  1  one-cycle pulse; begins a transfer (ignored unless IDLE)
- Seed  input  DATA_W  initial accumulator value, latched on accepted Start
- BaseAddr  input  ADDR_W  first write address, latched on accepted Start
- Len  input  ADDR_W+1  number of differences to consume, latched on accepted Start
- DiffIn  input  DATA_W  signed difference
- DiffValid  input  1  DiffIn is valid
- DiffReady  output  1  block can accept DiffIn this cycle
- WEn  output  1  destination write strobe
- WAddr  output  ADDR_W  destination write address
- WData  output  DATA_W  rebuilt sample
- Busy  output  1  high in RUN and DRAIN
- Done  output  1  one-cycle pulse at transfer end
- Ovf  output  1  sticky signed-overflow flag for the current transfer

Behaviour:
- Reset, asynchronous on Rst_n low:
  - state = IDLE.
  - All outputs 0: DiffReady, WEn, WAddr, WData, Busy, Done, Ovf.
  - Acc, Count and the address pointer = 0.
- States are IDLE, RUN, DRAIN.
- IDLE:
  - Start=1 latches Seed into Acc, BaseAddr into the pointer and Len into Count, and clears Ovf.
  - If Len != 0, go to RUN.
  - If Len == 0, Done pulses next cycle and state stays IDLE. No write is issued.
- RUN:
  - DiffReady = 1 combinationally.
  - A beat is accepted when DiffValid && DiffReady.
  - On an accepted beat: Acc <= Acc + DiffIn, Count <= Count - 1.
  - The next cycle registers WEn = 1, WAddr = pointer, WData = the new Acc. The pointer then increments, wrapping modulo 2^ADDR_W.
  - Latency: one cycle from accepted beat to WEn.
  - Full throughput: one beat per cycle, no bubbles required.
  - No beat: WEn = 0, and WAddr/WData hold their last values.
  - When the beat that takes Count to 0 is accepted, go to DRAIN.
- DRAIN:
  - DiffReady = 0.
  - The final write is presented this cycle and Done pulses in the same cycle.
  - Next state is IDLE.
- Start while Busy: ignored. No relatch, no effect on the transfer.
- Arithmetic is DATA_W-bit two's complement.
- Overflow occurs when both operands have the same sign and the result sign differs. It sets Ovf, which stays set until the next accepted Start or reset.
- Default (no macro): the sum wraps modulo 2^DATA_W, so rebuilt data is bit-exact against the wrapping subtractor.
- Reset mid-transfer:
  - State returns to IDLE immediately and any pending write is dropped.
  - WEn is 0 while Rst_n is low and stays 0 until a new transfer.
- DiffValid while IDLE or DRAIN: not accepted, no state change.

Optional Feature:
- Macro: DELTA_WRITER_SAT_EN.
- Defined: on overflow the result clamps to the signed limit instead of wrapping.
  - Positive overflow clamps to 0x7F (DATA_W=8).
  - Negative overflow clamps to 0x80.
  - Ovf is still set.
- Undefined: wraparound as above. Ovf behaviour is identical in both builds.

Test Plan:
- Basic run:
  - Stimulus: Seed=0x10, BaseAddr=2, Len=3, diffs 0x05, 0xFE, 0x00 back-to-back.
  - Response: writes (2,0x15), (3,0x13), (4,0x13) on consecutive cycles, Done in the last write cycle, Ovf=0.
- Positive overflow:
  - Stimulus: Seed=0x7F, Len=1, diff 0x01.
  - Response: WData=0x80 with Ovf=1; with DELTA_WRITER_SAT_EN, WData=0x7F with Ovf=1.
- Negative overflow:
  - Stimulus: Seed=0x80, Len=1, diff 0xFF.
  - Response: WData=0x7F with Ovf=1; with DELTA_WRITER_SAT_EN, WData=0x80.
- Gapped DiffValid with address wrap:
  - Stimulus: Len=4, BaseAddr=14, DiffValid toggling 1,0,1,0,...
  - Response: WEn only on the cycle after each accepted beat, addresses 14,15,0,1.
- Len=0 and Start-while-busy:
  - Stimulus: Len=0; separately, a Start pulse mid-RUN with a different Seed.
  - Response: Len=0 gives Done one cycle later with no WEn; the mid-RUN Start is ignored and the output sequence is unchanged.
- Reset mid-RUN:
  - Stimulus: drop Rst_n after 2 of 5 beats.
  - Response: all outputs 0 immediately. A new Start afterwards runs cleanly from the new Seed with Ovf cleared.
